// File: rtl/algo_nr2w_err_mon.sv
// rtl/algo_nr2w_err_mon.sv - per-port read error gating, counters, double-error log and interrupt
module algo_nr2w_err_mon #(
  parameter int NUMRDPT   = 2,
  parameter int BITPADR   = 17,
  parameter int CNTWDTH   = 16,
  parameter int SERR_THRS = 16,
  parameter int FLOPOUT   = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ready_in,
  input  logic [NUMRDPT-1:0]         rd_vld_in,
  input  logic [NUMRDPT-1:0]         rd_serr_in,
  input  logic [NUMRDPT-1:0]         rd_derr_in,
  input  logic [NUMRDPT*BITPADR-1:0] rd_padr_in,
  output logic [NUMRDPT-1:0]         rd_vld,
  output logic [NUMRDPT-1:0]         rd_serr,
  output logic [NUMRDPT-1:0]         rd_derr,
  output logic [NUMRDPT*BITPADR-1:0] rd_padr,
  output logic [CNTWDTH-1:0]         serr_cnt,
  output logic [CNTWDTH-1:0]         derr_cnt,
  input  logic                       cnt_clr,
  output logic                       log_vld,
  output logic [2:0]                 log_port,
  output logic [BITPADR-1:0]         log_padr,
  output logic                       log_ovf,
  input  logic                       log_clr,
  output logic                       err_int
);

  localparam int SUMW = CNTWDTH + 4;
  localparam logic [SUMW-1:0]    CNT_MAX = {4'b0, {CNTWDTH{1'b1}}};
  localparam logic [CNTWDTH-1:0] THRS    = CNTWDTH'(SERR_THRS);

  typedef enum logic {IDLE, CAPT} state_t;

  state_t               state, state_nxt;
  logic [NUMRDPT-1:0]   gserr, gderr;
  logic [3:0]           serr_pop, derr_pop;
  logic [CNTWDTH-1:0]   serr_nxt, derr_nxt;
  logic [2:0]           low_port;
  logic [BITPADR-1:0]   low_padr;
  logic [2:0]           log_port_nxt;
  logic [BITPADR-1:0]   log_padr_nxt;
  logic                 log_ovf_nxt;

  function automatic logic [3:0] popcnt(input logic [NUMRDPT-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < NUMRDPT; i++) c = c + 4'(v[i]);
    return c;
  endfunction

  // Sum is formed wider than the counter so the saturation test sees any carry.
  function automatic logic [CNTWDTH-1:0] sat_add(input logic [CNTWDTH-1:0] base,
                                                 input logic [3:0] inc);
    logic [SUMW-1:0] s;
    s = {4'b0, base} + {{CNTWDTH{1'b0}}, inc};
    return (s > CNT_MAX) ? {CNTWDTH{1'b1}} : s[CNTWDTH-1:0];
  endfunction

  // Gate raw error flags: need a valid read, a ready top, and an ECC-region address.
  always_comb begin
    gserr = '0;
    gderr = '0;
    for (int p = 0; p < NUMRDPT; p++) begin
      gserr[p] = rd_vld_in[p] & ready_in & rd_serr_in[p] & ~rd_padr_in[p*BITPADR + BITPADR-1];
      gderr[p] = rd_vld_in[p] & ready_in & rd_derr_in[p] & ~rd_padr_in[p*BITPADR + BITPADR-1];
    end
  end

  // Output stage: either one register slice or a straight pass-through.
  generate
    if (FLOPOUT != 0) begin : g_flop
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rd_vld  <= '0;
          rd_serr <= '0;
          rd_derr <= '0;
          rd_padr <= '0;
        end else begin
          rd_vld  <= rd_vld_in;
          rd_serr <= gserr;
          rd_derr <= gderr;
          rd_padr <= rd_padr_in;
        end
      end
    end else begin : g_comb
      // Held at zero while reset is asserted so every output reads 0 in reset.
      always_comb begin
        rd_vld  = rst ? rd_vld_in  : '0;
        rd_serr = rst ? gserr      : '0;
        rd_derr = rst ? gderr      : '0;
        rd_padr = rst ? rd_padr_in : '0;
      end
    end
  endgenerate

  // Next counter values; a clear loads this cycle's events rather than dropping them.
  always_comb begin
    serr_pop = popcnt(gserr);
    derr_pop = popcnt(gderr);
    serr_nxt = sat_add(cnt_clr ? '0 : serr_cnt, serr_pop);
    derr_nxt = sat_add(cnt_clr ? '0 : derr_cnt, derr_pop);
  end

  // Lowest-index port carrying a gated double error, and its address.
  always_comb begin
    low_port = 3'd0;
    low_padr = '0;
    for (int i = NUMRDPT-1; i >= 0; i--) begin
      if (gderr[i]) begin
        low_port = 3'(i);
        low_padr = rd_padr_in[i*BITPADR +: BITPADR];
      end
    end
  end

  // Log FSM next state and log contents.
  always_comb begin
    state_nxt    = state;
    log_port_nxt = log_port;
    log_padr_nxt = log_padr;
    log_ovf_nxt  = log_ovf;
    case (state)
      IDLE: begin
        if (|gderr) begin
          state_nxt    = CAPT;
          log_port_nxt = low_port;
          log_padr_nxt = low_padr;
          log_ovf_nxt  = (derr_pop > 4'd1);
        end
      end
      CAPT: begin
        if (log_clr) begin
          log_ovf_nxt = 1'b0;
          if (|gderr) begin
            log_port_nxt = low_port;
            log_padr_nxt = low_padr;
          end else begin
            state_nxt = IDLE;
          end
        end else if (|gderr) begin
          log_ovf_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters, log registers and interrupt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      serr_cnt <= '0;
      derr_cnt <= '0;
      log_port <= '0;
      log_padr <= '0;
      log_ovf  <= 1'b0;
      err_int  <= 1'b0;
    end else begin
      state    <= state_nxt;
      serr_cnt <= serr_nxt;
      derr_cnt <= derr_nxt;
      log_port <= log_port_nxt;
      log_padr <= log_padr_nxt;
      log_ovf  <= log_ovf_nxt;
      err_int  <= (state_nxt == CAPT) | (serr_nxt >= THRS);
    end
  end

  assign log_vld = (state == CAPT);

endmodule

// File: tb/tb_algo_nr2w_err_mon.sv
// tb/tb_algo_nr2w_err_mon.sv - directed self-checking bench for algo_nr2w_err_mon
module tb_algo_nr2w_err_mon;

  localparam int N = 2;
  localparam int B = 17;
  localparam int W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             ready_in;
  logic [N-1:0]     rd_vld_in, rd_serr_in, rd_derr_in;
  logic [N*B-1:0]   rd_padr_in;
  logic             cnt_clr, log_clr;

  logic [N-1:0]     rd_vld, rd_serr, rd_derr;
  logic [N*B-1:0]   rd_padr;
  logic [W-1:0]     serr_cnt, derr_cnt;
  logic             log_vld, log_ovf, err_int;
  logic [2:0]       log_port;
  logic [B-1:0]     log_padr;

  logic [N-1:0]     c_vld, c_serr, c_derr;
  logic [N*B-1:0]   c_padr;
  logic [W-1:0]     c_serr_cnt, c_derr_cnt;
  logic             c_log_vld, c_log_ovf, c_err_int;
  logic [2:0]       c_log_port;
  logic [B-1:0]     c_log_padr;

  int tests  = 0;
  int failed = 0;

  algo_nr2w_err_mon #(.NUMRDPT(N), .BITPADR(B), .CNTWDTH(W), .SERR_THRS(3), .FLOPOUT(1)) u_dut (
    .clk(clk), .rst(rst), .ready_in(ready_in),
    .rd_vld_in(rd_vld_in), .rd_serr_in(rd_serr_in), .rd_derr_in(rd_derr_in), .rd_padr_in(rd_padr_in),
    .rd_vld(rd_vld), .rd_serr(rd_serr), .rd_derr(rd_derr), .rd_padr(rd_padr),
    .serr_cnt(serr_cnt), .derr_cnt(derr_cnt), .cnt_clr(cnt_clr),
    .log_vld(log_vld), .log_port(log_port), .log_padr(log_padr), .log_ovf(log_ovf),
    .log_clr(log_clr), .err_int(err_int)
  );

  algo_nr2w_err_mon #(.NUMRDPT(N), .BITPADR(B), .CNTWDTH(W), .SERR_THRS(3), .FLOPOUT(0)) u_comb (
    .clk(clk), .rst(rst), .ready_in(ready_in),
    .rd_vld_in(rd_vld_in), .rd_serr_in(rd_serr_in), .rd_derr_in(rd_derr_in), .rd_padr_in(rd_padr_in),
    .rd_vld(c_vld), .rd_serr(c_serr), .rd_derr(c_derr), .rd_padr(c_padr),
    .serr_cnt(c_serr_cnt), .derr_cnt(c_derr_cnt), .cnt_clr(cnt_clr),
    .log_vld(c_log_vld), .log_port(c_log_port), .log_padr(c_log_padr), .log_ovf(c_log_ovf),
    .log_clr(log_clr), .err_int(c_err_int)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    ready_in   = 1'b1;
    rd_vld_in  = '0;
    rd_serr_in = '0;
    rd_derr_in = '0;
    rd_padr_in = '0;
    cnt_clr    = 1'b0;
    log_clr    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    rd_vld_in = 2'b11;
    step();
    step();
    tests++; if (rd_vld !== 2'b00) begin failed++; $display("FAIL reset_rd_vld got %b exp 00", rd_vld); end
    tests++; if (c_vld !== 2'b00) begin failed++; $display("FAIL reset_comb_vld got %b exp 00", c_vld); end
    tests++; if ({serr_cnt, derr_cnt} !== 8'h00) begin failed++; $display("FAIL reset_cnt got %h exp 00", {serr_cnt, derr_cnt}); end
    tests++; if ({log_vld, log_ovf, err_int} !== 3'b000) begin failed++; $display("FAIL reset_log got %b exp 000", {log_vld, log_ovf, err_int}); end
    idle_inputs();
    rst = 1'b1;
  endtask

  task automatic test_passthrough();
    rd_vld_in  = 2'b11;
    rd_serr_in = 2'b01;
    rd_padr_in = {17'h00020, 17'h00010};
    step();
    tests++; if (rd_serr !== 2'b01) begin failed++; $display("FAIL pass_rd_serr got %b exp 01", rd_serr); end
    tests++; if (rd_vld !== 2'b11) begin failed++; $display("FAIL pass_rd_vld got %b exp 11", rd_vld); end
    tests++; if (rd_padr !== {17'h00020, 17'h00010}) begin failed++; $display("FAIL pass_rd_padr got %h exp %h", rd_padr, {17'h00020, 17'h00010}); end
    tests++; if (serr_cnt !== 4'd1) begin failed++; $display("FAIL pass_serr_cnt got %0d exp 1", serr_cnt); end
    rd_serr_in = 2'b11;
    step();
    tests++; if (serr_cnt !== 4'd3 || err_int !== 1'b1) begin failed++; $display("FAIL pass_pre_rst got cnt %0d int %b exp 3 1", serr_cnt, err_int); end
    rst = 1'b0;
    #1;
    tests++; if ({rd_vld, rd_serr, serr_cnt, err_int} !== 9'd0) begin failed++; $display("FAIL midrst_outputs got %b exp 0", {rd_vld, rd_serr, serr_cnt, err_int}); end
    idle_inputs();
    step();
    rst = 1'b1;
  endtask

  task automatic test_gating();
    rd_vld_in  = 2'b11;
    rd_serr_in = 2'b11;
    rd_derr_in = 2'b10;
    rd_padr_in = {17'h10400, 17'h00005};
    #1;
    tests++; if ({c_serr, c_derr} !== 4'b0100) begin failed++; $display("FAIL gate_comb got %b exp 0100", {c_serr, c_derr}); end
    step();
    tests++; if (rd_serr !== 2'b01) begin failed++; $display("FAIL gate_rd_serr got %b exp 01", rd_serr); end
    tests++; if (rd_derr !== 2'b00) begin failed++; $display("FAIL gate_rd_derr got %b exp 00", rd_derr); end
    tests++; if (serr_cnt !== 4'd1 || derr_cnt !== 4'd0) begin failed++; $display("FAIL gate_cnt got %0d/%0d exp 1/0", serr_cnt, derr_cnt); end
    tests++; if (log_vld !== 1'b0) begin failed++; $display("FAIL gate_log_vld got %b exp 0", log_vld); end
    idle_inputs();
  endtask

  task automatic test_log();
    rd_vld_in  = 2'b11;
    rd_derr_in = 2'b11;
    rd_padr_in = {17'h00456, 17'h00123};
    step();
    tests++; if ({log_vld, log_port, log_ovf} !== 5'b1_000_1) begin failed++; $display("FAIL log_capt got %b exp 10001", {log_vld, log_port, log_ovf}); end
    tests++; if (log_padr !== 17'h00123) begin failed++; $display("FAIL log_padr got %h exp 00123", log_padr); end
    tests++; if (derr_cnt !== 4'd2 || err_int !== 1'b1) begin failed++; $display("FAIL log_cnt_int got %0d %b exp 2 1", derr_cnt, err_int); end
    rd_derr_in = 2'b10;
    rd_padr_in = {17'h00999, 17'h00123};
    step();
    tests++; if ({log_vld, log_port, log_ovf, log_padr} !== {5'b1_000_1, 17'h00123}) begin failed++; $display("FAIL log_hold got %b %h exp 10001 00123", {log_vld, log_port, log_ovf}, log_padr); end
    tests++; if (derr_cnt !== 4'd3) begin failed++; $display("FAIL log_derr_cnt got %0d exp 3", derr_cnt); end
    idle_inputs();
    log_clr = 1'b1;
    step();
    tests++; if ({log_vld, log_ovf, err_int} !== 3'b000) begin failed++; $display("FAIL log_clr got %b exp 000", {log_vld, log_ovf, err_int}); end
    idle_inputs();
    step();
    tests++; if (log_vld !== 1'b0) begin failed++; $display("FAIL log_clr_idle got %b exp 0", log_vld); end
  endtask

  task automatic test_back_to_back();
    rd_vld_in  = 2'b01;
    rd_derr_in = 2'b01;
    rd_padr_in = {17'h00000, 17'h00050};
    step();
    tests++; if ({log_vld, log_port, log_ovf} !== 5'b1_000_0) begin failed++; $display("FAIL b2b_capt got %b exp 10000", {log_vld, log_port, log_ovf}); end
    rd_vld_in  = 2'b10;
    rd_derr_in = 2'b10;
    rd_padr_in = {17'h00777, 17'h00000};
    log_clr    = 1'b1;
    step();
    tests++; if ({log_vld, log_port, log_ovf} !== 5'b1_001_0) begin failed++; $display("FAIL b2b_recapt got %b exp 10010", {log_vld, log_port, log_ovf}); end
    tests++; if (log_padr !== 17'h00777) begin failed++; $display("FAIL b2b_padr got %h exp 00777", log_padr); end
    tests++; if (derr_cnt !== 4'd5) begin failed++; $display("FAIL b2b_derr_cnt got %0d exp 5", derr_cnt); end
    idle_inputs();
    log_clr = 1'b1;
    step();
    idle_inputs();
    rd_vld_in  = 2'b11;
    rd_serr_in = 2'b11;
    cnt_clr    = 1'b1;
    step();
    tests++; if (serr_cnt !== 4'd2 || derr_cnt !== 4'd0) begin failed++; $display("FAIL cntclr_evt got %0d/%0d exp 2/0", serr_cnt, derr_cnt); end
    tests++; if ({log_vld, err_int} !== 2'b00) begin failed++; $display("FAIL cntclr_int got %b exp 00", {log_vld, err_int}); end
    idle_inputs();
  endtask

  task automatic test_saturation();
    int exp_cnt;
    cnt_clr = 1'b1;
    step();
    tests++; if (serr_cnt !== 4'd0) begin failed++; $display("FAIL sat_clr got %0d exp 0", serr_cnt); end
    idle_inputs();
    exp_cnt = 0;
    rd_vld_in  = 2'b11;
    rd_serr_in = 2'b11;
    for (int i = 0; i < 20; i++) begin
      step();
      exp_cnt = (exp_cnt + 2 > 15) ? 15 : exp_cnt + 2;
      tests++; if (serr_cnt !== W'(exp_cnt)) begin failed++; $display("FAIL sat_cnt[%0d] got %0d exp %0d", i, serr_cnt, exp_cnt); end
      tests++; if (err_int !== (exp_cnt >= 3)) begin failed++; $display("FAIL sat_int[%0d] got %b exp %b", i, err_int, exp_cnt >= 3); end
    end
    idle_inputs();
  endtask

  task automatic test_ready_low();
    cnt_clr = 1'b1;
    step();
    idle_inputs();
    ready_in   = 1'b0;
    rd_vld_in  = 2'b11;
    rd_serr_in = 2'b11;
    rd_derr_in = 2'b11;
    rd_padr_in = {17'h00002, 17'h00001};
    step();
    tests++; if ({rd_derr, rd_serr} !== 4'b0000) begin failed++; $display("FAIL rdy_flags got %b exp 0000", {rd_derr, rd_serr}); end
    tests++; if (rd_vld !== 2'b11) begin failed++; $display("FAIL rdy_vld got %b exp 11", rd_vld); end
    tests++; if ({serr_cnt, derr_cnt, log_vld} !== 9'd0) begin failed++; $display("FAIL rdy_hold got %b exp 0", {serr_cnt, derr_cnt, log_vld}); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_gating();
    test_log();
    test_back_to_back();
    test_saturation();
    test_ready_low();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/algo_nr2w_err_mon.md
Name: algo_nr2w_err_mon

Overview:
- Parametrised read-error monitor that sits between an NRmW algorithm top and its wrapper outputs.
- Generalises the fixed 2-read-port error gating to NUMRDPT ports.
- Per port it suppresses ECC error flags for reads whose physical address MSB is set (non-ECC/cache region), with an optional output flop.
- Adds saturating single/double error counters, a sticky first-double-error log with a clear handshake, and a level interrupt.

Parameters:
NUMRDPT, 2, number of read ports (1..8)
BITPADR, 17, physical address width per port; bit BITPADR-1 is the gating bit
CNTWDTH, 16, width of each error counter
SERR_THRS, 16, serr_cnt value at or above which err_int asserts (1..2^CNTWDTH-1)
FLOPOUT, 0, 1 = register the rd_* outputs (one extra cycle); 0 = combinational pass-through

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
ready_in  input  1  algorithm top ready; errors are ignored while low
rd_vld_in  input  NUMRDPT  per-port read valid from algorithm top
rd_serr_in  input  NUMRDPT  per-port single-bit error (raw)
rd_derr_in  input  NUMRDPT  per-port double-bit error (raw)
rd_padr_in  input  NUMRDPT*BITPADR  per-port physical address
rd_vld  output  NUMRDPT  valid, delayed by FLOPOUT
rd_serr  output  NUMRDPT  gated single error
rd_derr  output  NUMRDPT  gated double error
rd_padr  output  NUMRDPT*BITPADR  physical address, delayed by FLOPOUT
serr_cnt  output  CNTWDTH  saturating count of gated single errors
derr_cnt  output  CNTWDTH  saturating count of gated double errors
cnt_clr  input  1  synchronous clear of both counters
log_vld  output  1  a double error is captured
log_port  output  3  read port index of the captured error
log_padr  output  BITPADR  physical address of the captured error
log_ovf  output  1  a further double error occurred while log_vld=1
log_clr  input  1  acknowledge/clear of the log
err_int  output  1  interrupt: log_vld | (serr_cnt >= SERR_THRS)

Behaviour:
- Reset (rst=0, async): every output is 0, counters are 0, and the log FSM is in IDLE.
- Gating, per port p: gserr[p] = rd_vld_in[p] & ready_in & rd_serr_in[p] & ~padr_in[p][BITPADR-1]. gderr is formed the same way.
- The rd_* outputs carry rd_vld_in, gserr, gderr and rd_padr_in.
  - FLOPOUT=0: combinational.
  - FLOPOUT=1: registered, latency 1 cycle.
- Counters are registered and update the cycle after the event, independent of FLOPOUT.
  - Increment = popcount(gserr) (resp. gderr) in that cycle, 0..NUMRDPT.
  - Sum is computed at CNTWDTH+4 bits and saturates at 2^CNTWDTH-1; counters never wrap.
- cnt_clr=1: the counter loads that cycle's popcount, so a clear never loses a simultaneous event.
- Log FSM has two states: IDLE and CAPT.
  - IDLE: on any gderr, capture the lowest-index set port into log_port and its padr into log_padr, clear log_ovf, and go to CAPT.
  - CAPT with no log_clr: log contents hold. Any gderr sets log_ovf (sticky). More than one set gderr bit in the IDLE capture cycle also sets log_ovf.
  - CAPT, log_clr=1, no gderr: go to IDLE and clear log_ovf. log_vld drops the next cycle.
  - CAPT, log_clr=1 with gderr in the same cycle: recapture the new lowest-index error, stay in CAPT, clear log_ovf.
  - log_clr in IDLE has no effect.
- log_* outputs are registered (1 cycle after the event).
- err_int is registered and recomputed every cycle from the next-state values, so it asserts in the same cycle log_vld or the counter update becomes visible.
- ready_in low mid-stream: gated flags are 0, so counters and log hold. rd_vld still passes through.
- rst asserted mid-operation: immediate return to the reset state; any pending FLOPOUT stage is discarded.

Test Plan:
- Reset/pass-through, NUMRDPT=2, FLOPOUT=1: drive rd_vld_in=2'b11, serr=2'b01, padr MSB=0 on both ports → next cycle rd_serr=2'b01, rd_vld=2'b11, serr_cnt=1. Assert rst=0 mid-stream → all outputs 0 immediately.
- Gating: serr=2'b11, derr=2'b10, port1 padr MSB=1, port0 MSB=0 → rd_serr=2'b01, rd_derr=2'b00, serr_cnt +1, derr_cnt unchanged, log_vld=0.
- Log capture and overflow: cycle 0 derr on ports 0 and 1 with padr 0x00123/0x00456 → log_vld=1, log_port=0, log_padr=0x00123, log_ovf=1. Then derr in CAPT → fields hold, log_ovf stays 1. Then log_clr → log_vld=0 next cycle.
- Simultaneous clear and event: log_clr together with derr on port1 (padr 0x00777) → log_vld stays 1, log_port=1, log_padr=0x00777, log_ovf=0. cnt_clr together with serr=2'b11 → serr_cnt=2.
- Saturation and threshold, CNTWDTH=4, SERR_THRS=3: 20 cycles of serr=2'b11 → serr_cnt goes 2,4,…,15 and holds at 15 (no wrap). err_int rises in the cycle serr_cnt first reaches 4 (≥3).
- ready_in=0 with derr=2'b11 → counters and log unchanged, rd_derr=0, rd_vld still mirrors input.
